// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and sizing helper for the BCD-to-binary converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX   = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] DD_THRESH = 4'd8;
    localparam logic [BCD_DIGIT_W-1:0] DD_ADJ    = 4'd3;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    // Smallest w with 2^w > 10^digits - 1.
    function automatic int unsigned bin_w_min(input int unsigned digits);
        longint unsigned lim;
        int unsigned     w;
        lim = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            lim = lim * 64'd10;
        end
        w = 0;
        while ((64'd1 << w) < lim) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit correction for reverse double-dabble: values >= 8 lose 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= DD_THRESH) begin
            dout = din - DD_ADJ;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative multi-digit BCD-to-binary converter, one shift-and-adjust step per clock,
// with start/busy/done handshake.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGITS*BCD_DIGIT_W-1:0] bcd,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [BIN_W-1:0]          bin
);

    localparam int unsigned BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < bin_w_min(DIGITS)) begin : g_bad_width
        $error("BIN_W too small to hold the largest DIGITS-digit BCD value");
    end

    state_e             state_q;
    logic [BCD_W-1:0]   dig_q;
    logic [BIN_W-1:0]   bsh_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [BIN_W-1:0]   bin_q;

    logic [BCD_W-1:0]   dig_shift;
    logic [BCD_W-1:0]   dig_adj;
    logic [BIN_W-1:0]   bsh_next;
    logic               bad_in;
    logic               capture;

    always_comb begin
        {dig_shift, bsh_next} = {dig_q, bsh_q} >> 1;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (dig_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (dig_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX) begin
                bad_in = 1'b1;
            end
        end
    end

    // Leaving DONE with start held counts as the next IDLE edge, giving one
    // result every BIN_W+2 cycles under a continuous request.
    always_comb begin
        capture = start && ((state_q == IDLE) || (state_q == DONE));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dig_q   <= '0;
            bsh_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (capture) begin
                dig_q   <= bcd;
                bsh_q   <= '0;
                busy_q  <= 1'b1;
                err_q   <= bad_in;
                state_q <= CONV;
                // A bad operand skips all iterations and exits to DONE next edge.
                cnt_q   <= bad_in ? '0 : CNT_W'(BIN_W);
            end else begin
                unique case (state_q)
                    IDLE: begin
                        busy_q <= 1'b0;
                    end
                    CONV: begin
                        if (cnt_q != '0) begin
                            dig_q <= dig_adj;
                            bsh_q <= bsh_next;
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            bin_q   <= err_q ? '0 : bsh_q;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign bin  = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (4 digits, 14-bit result).
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bcd;
    logic        busy;
    logic        done;
    logic        err;
    logic [13:0] bin;

    int n_chk  = 0;
    int n_pass = 0;

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bin   (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Digit register must be fully drained whenever a valid result is presented.
    always @(negedge clk) begin
        if (rst && done && !err) begin
            check("dig_zero", 32'(dut.dig_q), 32'd0);
            dig_zero_a: assert (dut.dig_q == '0)
                else $error("FAIL dig_zero_assert dig=%h expected 0", dut.dig_q);
        end
    end

    // Leaves the bench at the negedge after the capture edge (cycle 0).
    task automatic start_pulse(input logic [15:0] v);
        @(negedge clk);
        bcd   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle index of done; busy must stay high until then.
    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    int lat;
    bit bok;
    int d_cnt;
    int d_t[3];
    logic [13:0] d_bin[3];

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        bcd   = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_bin",  32'(bin),  32'd0);
        rst = 1'b1;

        // Zero operand: latency and busy window.
        start_pulse(16'h0000);
        wait_done(lat, bok);
        check("zero_lat",  32'(lat), 32'd15);
        check("zero_busy", 32'(bok), 32'd1);
        check("zero_bin",  32'(bin), 32'd0);
        check("zero_err",  32'(err), 32'd0);
        @(negedge clk);
        check("zero_done_1cyc", 32'(done), 32'd0);
        check("zero_busy_off",  32'(busy), 32'd0);

        // Largest operand.
        start_pulse(16'h9999);
        wait_done(lat, bok);
        check("max_lat", 32'(lat), 32'd15);
        check("max_bin", 32'(bin), 32'd9999);
        check("max_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);

        // Start held high: back-to-back results.
        bcd   = 16'h1234;
        start = 1'b1;
        d_cnt = 0;
        @(negedge clk);
        for (int t = 0; t < 50; t++) begin
            if (done && d_cnt < 3) begin
                d_t[d_cnt]   = t;
                d_bin[d_cnt] = bin;
                d_cnt++;
            end
            if (t == 39) start = 1'b0;
            @(negedge clk);
        end
        check("b2b_count",  32'(d_cnt), 32'd3);
        check("b2b_first",  32'(d_t[0]), 32'd15);
        check("b2b_gap",    32'(d_t[1] - d_t[0]), 32'd16);
        check("b2b_bin0",   32'(d_bin[0]), 32'h04D2);
        check("b2b_bin1",   32'(d_bin[1]), 32'h04D2);
        check("b2b_idle",   32'(busy), 32'd0);

        // Invalid digit, then recovery.
        start_pulse(16'h12A4);
        wait_done(lat, bok);
        check("bad_lat", 32'(lat), 32'd1);
        check("bad_err", 32'(err), 32'd1);
        check("bad_bin", 32'(bin), 32'd0);
        repeat (4) @(negedge clk);
        check("bad_err_held", 32'(err), 32'd1);
        start_pulse(16'h0007);
        check("rec_err_clr", 32'(err), 32'd0);
        wait_done(lat, bok);
        check("rec_lat", 32'(lat), 32'd15);
        check("rec_bin", 32'(bin), 32'd7);
        check("rec_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);

        // Start while busy is ignored.
        start_pulse(16'h0500);
        d_cnt = 0;
        lat   = -1;
        for (int t = 0; t < 40; t++) begin
            if (t == 3) begin
                bcd   = 16'h0001;
                start = 1'b1;
            end
            if (t == 4) start = 1'b0;
            if (done) begin
                d_cnt++;
                lat = t;
            end
            @(negedge clk);
        end
        check("ign_count", 32'(d_cnt), 32'd1);
        check("ign_lat",   32'(lat),   32'd15);
        check("ign_bin",   32'(bin),   32'd500);

        // Asynchronous reset mid-conversion.
        start_pulse(16'h4321);
        repeat (5) @(negedge clk);
        check("rst_bin_held", 32'(bin), 32'd500);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err",  32'(err),  32'd0);
        check("arst_bin",  32'(bin),  32'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        d_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            if (done) d_cnt++;
            @(negedge clk);
        end
        check("arst_no_done", 32'(d_cnt), 32'd0);
        start_pulse(16'h4321);
        wait_done(lat, bok);
        check("arst_lat", 32'(lat), 32'd15);
        check("arst_bin2", 32'(bin), 32'd4321);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
